// File: rtl/eth_mdio_pkg.sv
// Shared MDIO definitions: opcodes, frame-parser states, preamble length, reg 0 default.
package eth_mdio_pkg;

  localparam logic [1:0]  OP_READ      = 2'b10;
  localparam logic [1:0]  OP_WRITE     = 2'b01;
  localparam int          PREAMBLE_LEN = 32;
  localparam logic [15:0] REG0_RST     = 16'h3100;

  typedef enum logic [2:0] {
    ST_PRE   = 3'd0,
    ST_ST    = 3'd1,
    ST_OP    = 3'd2,
    ST_PHYAD = 3'd3,
    ST_REGAD = 3'd4,
    ST_TA    = 3'd5,
    ST_DATA  = 3'd6
  } mdio_state_e;

  // Regs 1..3 (status, ID1, ID2) cannot be written.
  function automatic logic reg_is_ro(input logic [4:0] a);
    return (a != 5'd0) && (a < 5'd4);
  endfunction

endpackage

// File: rtl/mdio_sync_edge.sv
// Two-flop synchronizer for MDC/MDIO with registered MDC rising-edge strobe.
module mdio_sync_edge (
  input  logic Clk,
  input  logic Rstn,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic mdc_rise,
  output logic mdio_s
);

  logic mdc_s1_q, mdc_s2_q, mdc_s3_q;
  logic mdio_s1_q, mdio_s2_q;
  logic rise_q, rise_d;
  logic bit_q, bit_d;

  // Edge strobe and the MDIO bit are registered together so they stay aligned.
  always_comb begin
    rise_d = mdc_s2_q & ~mdc_s3_q;
    bit_d  = mdio_s2_q;
  end

  // Synchronizer chains plus aligned output stage.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      mdc_s1_q  <= 1'b0;
      mdc_s2_q  <= 1'b0;
      mdc_s3_q  <= 1'b0;
      mdio_s1_q <= 1'b1;
      mdio_s2_q <= 1'b1;
      rise_q    <= 1'b0;
      bit_q     <= 1'b1;
    end else begin
      mdc_s1_q  <= mdc_i;
      mdc_s2_q  <= mdc_s1_q;
      mdc_s3_q  <= mdc_s2_q;
      mdio_s1_q <= mdio_i;
      mdio_s2_q <= mdio_s1_q;
      rise_q    <= rise_d;
      bit_q     <= bit_d;
    end
  end

  assign mdc_rise = rise_q;
  assign mdio_s   = bit_q;

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO PHY target: frame parser, 32x16 register file, read-data drive.
module mdio_phy_responder
  import eth_mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR   = 5'd1,
  parameter logic [15:0] PHY_ID1    = 16'h2000,
  parameter logic [15:0] PHY_ID2    = 16'h5C90,
  parameter logic [15:0] PHY_STATUS = 16'h782D
) (
  input  logic        Clk,
  input  logic        Rstn,
  input  logic        MDC,
  input  logic        MDIO_I,
  output logic        MDIO_O,
  output logic        MDIO_Oe,
  output logic        Reg_Wr_Valid,
  output logic [4:0]  Reg_Wr_Addr,
  output logic [15:0] Reg_Wr_Data,
  output logic        Frame_Err
);

  localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_LEN);

  function automatic logic [15:0] reg_rst(input int i);
    case (i)
      0:       return REG0_RST;
      1:       return PHY_STATUS;
      2:       return PHY_ID1;
      3:       return PHY_ID2;
      default: return 16'h0000;
    endcase
  endfunction

  logic mdc_rise, mdio_bit;

  mdio_sync_edge u_sync (
    .Clk      (Clk),
    .Rstn     (Rstn),
    .mdc_i    (MDC),
    .mdio_i   (MDIO_I),
    .mdc_rise (mdc_rise),
    .mdio_s   (mdio_bit)
  );

  mdio_state_e state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic        op_hi_q, op_hi_d;
  logic        op_rd_q, op_rd_d;
  logic [4:0]  phyad_q, phyad_d;
  logic [4:0]  regad_q, regad_d;
  logic [15:0] shift_q, shift_d;
  logic        oe_q, oe_d;
  logic        o_q, o_d;
  logic        tail_q, tail_d;
  logic        sr_clr_q, sr_clr_d;
  logic        wr_valid_q, wr_valid_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        ferr_q, ferr_d;
  logic [15:0] regs_q [32];
  logic [15:0] regs_d [32];

  logic [15:0] wdata;
  logic        addr_ok;

  assign wdata   = {shift_q[14:0], mdio_bit};
  assign addr_ok = (phyad_q == PHY_ADDR);

  // Frame parser, read drive and register-file update; all protocol steps gated by mdc_rise.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    pre_cnt_d  = pre_cnt_q;
    op_hi_d    = op_hi_q;
    op_rd_d    = op_rd_q;
    phyad_d    = phyad_q;
    regad_d    = regad_q;
    shift_d    = shift_q;
    oe_d       = oe_q;
    o_d        = o_q;
    tail_d     = tail_q;
    sr_clr_d   = 1'b0;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    ferr_d     = 1'b0;
    regs_d     = regs_q;

    // Soft reset bit drops one cycle after being written as 1.
    if (sr_clr_q) regs_d[0][15] = 1'b0;

    if (mdc_rise) begin
      // D0 was driven on the previous edge; the master has now sampled it.
      if (tail_q) begin
        oe_d   = 1'b0;
        o_d    = 1'b0;
        tail_d = 1'b0;
      end

      case (state_q)
        ST_PRE: begin
          if (mdio_bit) begin
            if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + 6'd1;
          end else if (pre_cnt_q == PRE_MAX) begin
            state_d   = ST_ST;
            pre_cnt_d = 6'd0;
          end else begin
            pre_cnt_d = 6'd0;
          end
        end

        ST_ST: begin
          if (mdio_bit) begin
            state_d   = ST_OP;
            bit_cnt_d = 5'd1;
          end else begin
            state_d = ST_PRE;
            ferr_d  = 1'b1;
          end
        end

        ST_OP: begin
          op_hi_d = mdio_bit;
          if (bit_cnt_q != 5'd0) begin
            bit_cnt_d = bit_cnt_q - 5'd1;
          end else if ({op_hi_q, mdio_bit} == OP_READ) begin
            op_rd_d   = 1'b1;
            state_d   = ST_PHYAD;
            bit_cnt_d = 5'd4;
          end else if ({op_hi_q, mdio_bit} == OP_WRITE) begin
            op_rd_d   = 1'b0;
            state_d   = ST_PHYAD;
            bit_cnt_d = 5'd4;
          end else begin
            state_d = ST_PRE;
            ferr_d  = 1'b1;
          end
        end

        ST_PHYAD: begin
          phyad_d = {phyad_q[3:0], mdio_bit};
          if (bit_cnt_q != 5'd0) begin
            bit_cnt_d = bit_cnt_q - 5'd1;
          end else begin
            state_d   = ST_REGAD;
            bit_cnt_d = 5'd4;
          end
        end

        ST_REGAD: begin
          regad_d = {regad_q[3:0], mdio_bit};
          if (bit_cnt_q != 5'd0) begin
            bit_cnt_d = bit_cnt_q - 5'd1;
          end else begin
            state_d   = ST_TA;
            bit_cnt_d = 5'd1;
          end
        end

        ST_TA: begin
          // Write turnaround must be 1 then 0; read turnaround belongs to the PHY.
          if (bit_cnt_q != 5'd0) begin
            if (!op_rd_q && !mdio_bit) begin
              state_d = ST_PRE;
              ferr_d  = 1'b1;
            end else begin
              bit_cnt_d = 5'd0;
            end
          end else if (!op_rd_q && mdio_bit) begin
            state_d = ST_PRE;
            ferr_d  = 1'b1;
          end else begin
            state_d   = ST_DATA;
            bit_cnt_d = 5'd15;
            shift_d   = regs_q[regad_q];
            if (op_rd_q && addr_ok) begin
              oe_d = 1'b1;
              o_d  = 1'b0;
            end
          end
        end

        ST_DATA: begin
          o_d     = oe_q ? shift_q[15] : 1'b0;
          shift_d = wdata;
          if (bit_cnt_q != 5'd0) begin
            bit_cnt_d = bit_cnt_q - 5'd1;
          end else begin
            state_d   = ST_PRE;
            pre_cnt_d = 6'd0;
            tail_d    = oe_q;
            if (!op_rd_q && addr_ok && !reg_is_ro(regad_q)) begin
              regs_d[regad_q] = wdata;
              wr_valid_d      = 1'b1;
              wr_addr_d       = regad_q;
              wr_data_d       = wdata;
              sr_clr_d        = (regad_q == 5'd0) && wdata[15];
            end
          end
        end

        default: begin
          state_d   = ST_PRE;
          pre_cnt_d = 6'd0;
        end
      endcase
    end
  end

  // State and output registers; reset releases MDIO and restores register defaults.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state_q    <= ST_PRE;
      bit_cnt_q  <= 5'd0;
      pre_cnt_q  <= 6'd0;
      op_hi_q    <= 1'b0;
      op_rd_q    <= 1'b0;
      phyad_q    <= 5'd0;
      regad_q    <= 5'd0;
      shift_q    <= 16'h0000;
      oe_q       <= 1'b0;
      o_q        <= 1'b0;
      tail_q     <= 1'b0;
      sr_clr_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 5'd0;
      wr_data_q  <= 16'h0000;
      ferr_q     <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= reg_rst(i);
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      pre_cnt_q  <= pre_cnt_d;
      op_hi_q    <= op_hi_d;
      op_rd_q    <= op_rd_d;
      phyad_q    <= phyad_d;
      regad_q    <= regad_d;
      shift_q    <= shift_d;
      oe_q       <= oe_d;
      o_q        <= o_d;
      tail_q     <= tail_d;
      sr_clr_q   <= sr_clr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ferr_q     <= ferr_d;
      regs_q     <= regs_d;
    end
  end

  assign MDIO_O       = o_q;
  assign MDIO_Oe      = oe_q;
  assign Reg_Wr_Valid = wr_valid_q;
  assign Reg_Wr_Addr  = wr_addr_q;
  assign Reg_Wr_Data  = wr_data_q;
  assign Frame_Err    = ferr_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: bit-level MDIO master plus register-file reference model.
module tb_mdio_phy_responder;

  localparam logic [4:0] PHY = 5'd1;

  logic        Clk = 1'b0;
  logic        Rstn = 1'b1;
  logic        MDC = 1'b0;
  logic        MDIO_I = 1'b1;
  logic        MDIO_O, MDIO_Oe, Reg_Wr_Valid, Frame_Err;
  logic [4:0]  Reg_Wr_Addr;
  logic [15:0] Reg_Wr_Data;

  mdio_phy_responder dut (
    .Clk          (Clk),
    .Rstn         (Rstn),
    .MDC          (MDC),
    .MDIO_I       (MDIO_I),
    .MDIO_O       (MDIO_O),
    .MDIO_Oe      (MDIO_Oe),
    .Reg_Wr_Valid (Reg_Wr_Valid),
    .Reg_Wr_Addr  (Reg_Wr_Addr),
    .Reg_Wr_Data  (Reg_Wr_Data),
    .Frame_Err    (Frame_Err)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int errs = 0;
  int wr_cnt = 0;
  int ferr_cnt = 0;
  logic [4:0]  wr_addr_seen;
  logic [15:0] wr_data_seen;

  // Pulse monitors sampled on the inactive clock edge.
  always @(negedge Clk) begin
    if (Reg_Wr_Valid === 1'b1) begin
      wr_cnt++;
      wr_addr_seen = Reg_Wr_Addr;
      wr_data_seen = Reg_Wr_Data;
    end
    if (Frame_Err === 1'b1) ferr_cnt++;
  end

  logic [15:0] mregs [32];
  bit   fq [$];
  logic smp_o [$];
  logic smp_oe [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 16'h0000;
    mregs[0] = 16'h3100;
    mregs[1] = 16'h782D;
    mregs[2] = 16'h2000;
    mregs[3] = 16'h5C90;
  endtask

  // One MDC period: master changes MDIO while MDC is low, target outputs sampled late in the period.
  task automatic send_bit(input bit b);
    MDIO_I = b;
    repeat (10) @(posedge Clk);
    MDC = 1'b1;
    repeat (10) @(posedge Clk);
    MDC = 1'b0;
    #1;
    smp_o.push_back(MDIO_O);
    smp_oe.push_back(MDIO_Oe);
  endtask

  // Frame layout: preamble, ST=01, OP, PHYAD, REGAD, TA, DATA, then one idle 0.
  task automatic build(input int pre, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] rg, input logic [1:0] ta, input logic [15:0] d);
    fq.delete();
    for (int i = 0; i < pre; i++) fq.push_back(1'b1);
    fq.push_back(1'b0); fq.push_back(1'b1);
    for (int i = 1; i >= 0; i--) fq.push_back(op[i]);
    for (int i = 4; i >= 0; i--) fq.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) fq.push_back(rg[i]);
    for (int i = 1; i >= 0; i--) fq.push_back(ta[i]);
    for (int i = 15; i >= 0; i--) fq.push_back(d[i]);
    fq.push_back(1'b0);
  endtask

  task automatic run(input int n);
    smp_o.delete();
    smp_oe.delete();
    for (int i = 0; i < n; i++) send_bit(fq[i]);
  endtask

  function automatic int oe_cycles();
    int c = 0;
    foreach (smp_oe[i]) if (smp_oe[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic do_read(input logic [4:0] phy, input logic [4:0] rg, input int pre, input string tag);
    int f0, w0;
    bit hit;
    logic [15:0] word;
    f0 = ferr_cnt;
    w0 = wr_cnt;
    build(pre, 2'b10, phy, rg, 2'b11, 16'hFFFF);
    run(fq.size());
    hit = (pre >= 32) && (phy == PHY);
    chk({tag, " oe_cycles"}, 32'(oe_cycles()), hit ? 32'd17 : 32'd0);
    if (hit) begin
      chk({tag, " ta_bit"}, {31'd0, smp_o[pre + 15]}, 32'd0);
      for (int k = 0; k < 16; k++) word[15 - k] = smp_o[pre + 16 + k];
      chk({tag, " rdata"}, {16'd0, word}, {16'd0, mregs[rg]});
      chk({tag, " oe_released"}, {31'd0, smp_oe[pre + 32]}, 32'd0);
    end
    chk({tag, " ferr"}, 32'(ferr_cnt - f0), 32'd0);
    chk({tag, " no_wr"}, 32'(wr_cnt - w0), 32'd0);
  endtask

  task automatic do_write(input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] d,
                          input logic [1:0] ta, input string tag);
    int f0, w0;
    bit good, pulse;
    f0 = ferr_cnt;
    w0 = wr_cnt;
    build(32, 2'b01, phy, rg, ta, d);
    run(fq.size());
    good  = (ta == 2'b10);
    pulse = good && (phy == PHY) && !(rg >= 5'd1 && rg <= 5'd3);
    if (pulse) mregs[rg] = (rg == 5'd0) ? {1'b0, d[14:0]} : d;
    chk({tag, " ferr"}, 32'(ferr_cnt - f0), good ? 32'd0 : 32'd1);
    chk({tag, " wr_pulses"}, 32'(wr_cnt - w0), pulse ? 32'd1 : 32'd0);
    chk({tag, " oe_cycles"}, 32'(oe_cycles()), 32'd0);
    if (pulse) begin
      chk({tag, " wr_addr"}, {27'd0, wr_addr_seen}, {27'd0, rg});
      chk({tag, " wr_data"}, {16'd0, wr_data_seen}, {16'd0, d});
    end
  endtask

  initial begin
    int f0, w0;
    logic [4:0]  rg, phy;
    logic [15:0] d;

    model_reset();
    #2 Rstn = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    chk("reset outputs", {8'd0, MDIO_O, MDIO_Oe, Reg_Wr_Valid, Reg_Wr_Addr, Reg_Wr_Data, Frame_Err}, 32'd0);
    Rstn = 1'b1;
    repeat (4) @(posedge Clk);

    do_read(PHY, 5'd2, 32, "read id1");
    do_write(PHY, 5'd4, 16'hA5A5, 2'b10, "write r4");
    do_read(PHY, 5'd4, 32, "read r4");
    do_write(PHY, 5'd0, 16'h8000, 2'b10, "write r0 softreset");
    do_read(PHY, 5'd0, 32, "read r0");
    do_write(PHY, 5'd1, 16'h1234, 2'b10, "write r1 ro");
    do_read(PHY, 5'd1, 32, "read r1");
    do_read(5'd5, 5'd2, 32, "read other phy");
    do_write(5'd5, 5'd6, 16'hBEEF, 2'b10, "write other phy");
    do_read(PHY, 5'd6, 32, "read r6");

    // Illegal opcode 11.
    f0 = ferr_cnt; w0 = wr_cnt;
    build(32, 2'b11, PHY, 5'd4, 2'b10, 16'h1234);
    run(fq.size());
    chk("op11 ferr", 32'(ferr_cnt - f0), 32'd1);
    chk("op11 no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("op11 oe", 32'(oe_cycles()), 32'd0);

    do_read(PHY, 5'd2, 31, "short preamble");
    do_write(PHY, 5'd5, 16'h5A5A, 2'b11, "write bad ta");
    do_read(PHY, 5'd5, 32, "read r5 after bad ta");
    do_read(PHY, 5'd3, 32, "read id2");

    // Randomized mix against the model.
    for (int n = 0; n < 14; n++) begin
      rg  = 5'($urandom_range(0, 7));
      phy = ($urandom_range(0, 3) == 0) ? 5'd5 : PHY;
      d   = 16'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(phy, rg, d, 2'b10, "rand write");
      else                           do_read(phy, rg, 32, "rand read");
    end

    // Reset in the middle of a read data phase.
    do_write(PHY, 5'd4, 16'hA5A5, 2'b10, "write r4 again");
    build(32, 2'b10, PHY, 5'd4, 2'b11, 16'hFFFF);
    run(32 + 16 + 5);
    chk("midread oe", {31'd0, smp_oe[smp_oe.size() - 1]}, 32'd1);
    Rstn = 1'b0;
    #1;
    chk("reset drops oe", {30'd0, MDIO_Oe, MDIO_O}, 32'd0);
    model_reset();
    repeat (3) @(posedge Clk);
    Rstn = 1'b1;
    repeat (4) @(posedge Clk);
    do_read(PHY, 5'd4, 32, "read r4 after reset");
    do_read(PHY, 5'd2, 32, "read id1 after reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
